// File: rtl/lmb_bram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lmb_bram_pkg
// Description : Shared state encoding, byte-lane constants and helpers for the
//               LMB BRAM interface controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lmb_bram_pkg;

    localparam int C_NUM_WE = 4;
    localparam int C_LANE_W = 8;

    localparam logic [0:3] C_BE_ALL  = 4'b1111;
    localparam logic [0:3] C_BE_NONE = 4'b0000;

    typedef logic [1:0] lmb_state_t;
    localparam lmb_state_t C_ST_INIT = 2'd0;
    localparam lmb_state_t C_ST_IDLE = 2'd1;
    localparam lmb_state_t C_ST_PEND = 2'd2;

    // Captured LMB request, reused for the one-entry pending slot.
    typedef struct packed {
        logic        hit;
        logic        rd;
        logic        wr;
        logic [0:3]  be;
        logic [0:31] addr;
        logic [0:31] data;
    } lmb_req_t;

    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lmb_bram_init_seq.sv
`default_nettype none
// ============================================================================
// Module      : lmb_bram_init_seq
// Description : Word counter that walks every BRAM word once for zero-fill.
// Revision    : 1.0 - initial release
// ============================================================================
module lmb_bram_init_seq
    import lmb_bram_pkg::*;
#(
    parameter int C_MEMSIZE = 'h10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    output logic        o_en,
    output logic [0:31] o_addr,
    output logic        o_last,
    output logic        o_done
);

    localparam int c_WORDS = C_MEMSIZE / C_NUM_WE;
    localparam int c_CW    = clog2(c_WORDS);

    logic [c_CW-1:0] r_cnt;
    logic            r_done;
    logic            w_last;

    assign w_last = (r_cnt == c_CW'(c_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (i_start) begin
            r_cnt <= w_last ? '0 : r_cnt + c_CW'(1);
            if (w_last) begin
                r_done <= 1'b1;
            end
        end
    end

    assign o_en   = i_start;
    assign o_addr = 32'({r_cnt, 2'b00});
    assign o_last = i_start && w_last;
    assign o_done = r_done;

endmodule
`default_nettype wire

// File: rtl/lmb_bram_if_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lmb_bram_if_ctrl
// Description : LMB slave controller driving BRAM port A, with optional
//               post-reset zero-fill and a one-entry pending slot.
// Revision    : 1.0 - initial release
// ============================================================================
module lmb_bram_if_ctrl
    import lmb_bram_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR    = 32'h0000_FFFF,
    parameter int          C_MEMSIZE     = 'h10000,
    parameter int          C_INIT_CLEAR  = 1,
    parameter int          C_PORT_DWIDTH = 32
) (
    input  logic                     LMB_Clk,
    input  logic                     LMB_Rst_N,
    input  logic [0:31]              LMB_ABus,
    input  logic [0:C_PORT_DWIDTH-1] LMB_WriteDBus,
    input  logic                     LMB_AddrStrobe,
    input  logic                     LMB_ReadStrobe,
    input  logic                     LMB_WriteStrobe,
    input  logic [0:3]               LMB_BE,
    output logic [0:C_PORT_DWIDTH-1] Sl_DBus,
    output logic                     Sl_Ready,
    output logic                     Sl_UE,
    output logic                     Init_Done,
    output logic                     BRAM_Rst_A,
    output logic                     BRAM_Clk_A,
    output logic                     BRAM_EN_A,
    output logic [0:3]               BRAM_WEN_A,
    output logic [0:31]              BRAM_Addr_A,
    output logic [0:C_PORT_DWIDTH-1] BRAM_Dout_A,
    input  logic [0:C_PORT_DWIDTH-1] BRAM_Din_A
);

    localparam lmb_state_t  c_ST_RST   = (C_INIT_CLEAR != 0) ? C_ST_INIT : C_ST_IDLE;
    localparam logic [31:0] c_OFF_MASK = 32'(C_MEMSIZE - 1) & 32'hFFFF_FFFC;
    localparam logic [31:0] c_SPAN     = C_HIGHADDR - C_BASEADDR;

    lmb_state_t r_state;
    lmb_state_t w_state_nxt;

    lmb_req_t   r_pend;
    logic       r_pend_valid;
    lmb_req_t   w_req_lmb;
    lmb_req_t   w_req_cur;

    logic        w_accept;
    logic        w_access;
    logic        w_is_read;
    logic        w_init_start;
    logic        w_init_en;
    logic        w_init_last;
    logic        w_init_done;
    logic        w_seq_done;
    logic [0:31] w_init_addr;

    logic        r_ready;
    logic        r_ue;
    logic        r_rd_hit;
    logic        r_rd_miss;
    logic [0:31] r_dbus;
    logic [0:31] w_sl_dbus;

    assign BRAM_Rst_A = ~LMB_Rst_N;
    assign BRAM_Clk_A = LMB_Clk;

    // Window check as an offset compare so a zero base needs no special case.
    assign w_req_lmb.hit  = ((LMB_ABus - C_BASEADDR) <= c_SPAN);
    assign w_req_lmb.rd   = LMB_ReadStrobe;
    assign w_req_lmb.wr   = LMB_WriteStrobe;
    assign w_req_lmb.be   = LMB_BE;
    assign w_req_lmb.addr = LMB_ABus;
    assign w_req_lmb.data = LMB_WriteDBus;

    assign w_req_cur = (r_state == C_ST_PEND) ? r_pend : w_req_lmb;
    assign w_accept  = ((r_state == C_ST_IDLE) && LMB_AddrStrobe) || (r_state == C_ST_PEND);
    assign w_access  = w_accept && w_req_cur.hit && (w_req_cur.rd || w_req_cur.wr);
    assign w_is_read = w_req_cur.rd && !w_req_cur.wr;

    assign w_init_start = (r_state == C_ST_INIT);

    lmb_bram_init_seq #(
        .C_MEMSIZE (C_MEMSIZE)
    ) u_init_seq (
        .clk     (LMB_Clk),
        .rst_n   (LMB_Rst_N),
        .i_start (w_init_start),
        .o_en    (w_init_en),
        .o_addr  (w_init_addr),
        .o_last  (w_init_last),
        .o_done  (w_seq_done)
    );

    generate
        if (C_INIT_CLEAR != 0) begin : g_init_clear
            assign w_init_done = w_seq_done;
        end else begin : g_init_skip
            logic r_skip_done;
            always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
                if (!LMB_Rst_N) begin
                    r_skip_done <= 1'b0;
                end else begin
                    r_skip_done <= 1'b1;
                end
            end
            assign w_init_done = r_skip_done;
        end
    endgenerate

    assign Init_Done = w_init_done;

    always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
        if (!LMB_Rst_N) begin
            r_state <= c_ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_INIT: begin
                if (w_init_last) begin
                    w_state_nxt = (r_pend_valid || LMB_AddrStrobe) ? C_ST_PEND : C_ST_IDLE;
                end
            end
            C_ST_PEND: w_state_nxt = C_ST_IDLE;
            C_ST_IDLE: w_state_nxt = C_ST_IDLE;
            default:   w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Port A is gated by reset so an abort silences the BRAM immediately.
    always_comb begin
        BRAM_EN_A   = 1'b0;
        BRAM_WEN_A  = C_BE_NONE;
        BRAM_Addr_A = '0;
        BRAM_Dout_A = '0;
        if (LMB_Rst_N) begin
            if (r_state == C_ST_INIT) begin
                BRAM_EN_A   = w_init_en;
                BRAM_WEN_A  = C_BE_ALL;
                BRAM_Addr_A = w_init_addr;
            end else begin
                BRAM_Addr_A = w_req_cur.addr & c_OFF_MASK;
                BRAM_Dout_A = w_req_cur.data;
                if (w_access) begin
                    BRAM_EN_A  = 1'b1;
                    BRAM_WEN_A = w_req_cur.wr ? w_req_cur.be : C_BE_NONE;
                end
            end
        end
    end

    always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
        if (!LMB_Rst_N) begin
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
        end else if ((r_state == C_ST_INIT) && LMB_AddrStrobe && !r_pend_valid) begin
            r_pend_valid <= 1'b1;
            r_pend       <= w_req_lmb;
        end else if (r_state == C_ST_PEND) begin
            r_pend_valid <= 1'b0;
        end
    end

    // BRAM read data arrives one cycle after enable and is passed through live.
    assign w_sl_dbus = r_rd_hit ? BRAM_Din_A : (r_rd_miss ? '0 : r_dbus);

    always_ff @(posedge LMB_Clk or negedge LMB_Rst_N) begin
        if (!LMB_Rst_N) begin
            r_ready   <= 1'b0;
            r_ue      <= 1'b0;
            r_rd_hit  <= 1'b0;
            r_rd_miss <= 1'b0;
            r_dbus    <= '0;
        end else begin
            r_ready   <= w_accept;
            r_ue      <= w_accept && !w_req_cur.hit;
            r_rd_hit  <= w_accept && w_req_cur.hit && w_is_read;
            r_rd_miss <= w_accept && !w_req_cur.hit && w_is_read;
            r_dbus    <= w_sl_dbus;
        end
    end

    assign Sl_Ready = r_ready;
    assign Sl_UE    = r_ue;
    assign Sl_DBus  = w_sl_dbus;

endmodule
`default_nettype wire
